// File: rtl/half_nn_pkg.sv
// Shared half-precision types, field masks and collector FSM encoding
// for the vector-dot-vector datapath.
package half_nn_pkg;

    typedef logic [15:0] half_t;

    localparam int    HALF_SIGN_BIT  = 15;
    localparam half_t HALF_EXP_MASK  = 16'h7C00;
    localparam half_t HALF_MANT_MASK = 16'h03FF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } collector_state_t;

    function automatic logic half_is_nan(input half_t v);
        return ((v & HALF_EXP_MASK) == HALF_EXP_MASK) && ((v & HALF_MANT_MASK) != '0);
    endfunction

endpackage

// File: rtl/half_layer_collector_if.sv
// Input scalar stream and output vector-beat handshake of the layer collector.
interface half_layer_collector_if #(
    parameter int BITS  = 16,
    parameter int MULTS = 2
);
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data [MULTS];
    logic            out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data, out_last
    );
endinterface

// File: rtl/half_relu.sv
// Half-precision ReLU: negative non-NaN values (including -0 and -inf)
// become +0, everything else, NaN of either sign included, passes through.
module half_relu
    import half_nn_pkg::*;
(
    input  half_t a,
    output half_t y
);
    assign y = (a[HALF_SIGN_BIT] && !half_is_nan(a)) ? '0 : a;
endmodule

// File: rtl/half_layer_collector.sv
// Gathers NEURONS dot-product results into ping-pong buffers and streams
// them out MULTS per beat. Define HALF_RELU_EN to apply ReLU on write.
module half_layer_collector
    import half_nn_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int NEURONS = 10,
    parameter int MULTS   = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    half_layer_collector_if.slave  bus,
    output logic                   overflow
);
    localparam int CHUNKS = NEURONS / MULTS;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int IW     = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NEURONS - 1);

    generate
        if (NEURONS % MULTS != 0) begin : g_bad_shape
            $error("NEURONS must be a multiple of MULTS");
        end
    endgenerate

    logic [BITS-1:0]  mem [2][NEURONS];
    logic [1:0]       full;
    logic [1:0]       set_mask;
    logic [1:0]       clr_mask;
    logic             wr_buf;
    logic             rd_buf;
    logic [IW-1:0]    wr_idx;
    logic [CW-1:0]    rd_chunk;
    logic [CW-1:0]    chunk_nx;
    collector_state_t state;
    collector_state_t state_nx;
    logic [BITS-1:0]  wr_data;
    logic             wr_en;
    logic             wr_done;
    logic             rd_done;
    logic             valid;

`ifdef HALF_RELU_EN
    half_relu u_relu (
        .a (bus.in_data),
        .y (wr_data)
    );
`else
    assign wr_data = bus.in_data;
`endif

    assign wr_en    = bus.in_valid && !full[wr_buf];
    assign wr_done  = wr_en && (wr_idx == LAST_IDX);
    assign set_mask = wr_done ? (wr_buf ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = rd_done ? (rd_buf ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_idx   <= '0;
            wr_buf   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (bus.in_valid && full[wr_buf])
                overflow <= 1'b1;
            if (wr_en) begin
                if (wr_done) begin
                    wr_idx <= '0;
                    wr_buf <= ~wr_buf;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    // Buffer contents are deliberately not reset; full flags gate their use.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_buf][wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            rd_chunk <= '0;
            rd_buf   <= 1'b0;
            full     <= '0;
        end else begin
            state    <= state_nx;
            rd_chunk <= chunk_nx;
            if (rd_done)
                rd_buf <= ~rd_buf;
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    always_comb begin
        state_nx = state;
        chunk_nx = rd_chunk;
        rd_done  = 1'b0;
        valid    = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_buf]) begin
                    state_nx = SEND;
                    chunk_nx = '0;
                end
            end
            SEND: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    if (rd_chunk == LAST_CHUNK) begin
                        rd_done  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        chunk_nx = rd_chunk + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.out_valid = valid;

    // The draining buffer cannot be written while full, so data holds under stall.
    always_comb begin
        bus.out_last = valid && (rd_chunk == LAST_CHUNK);
        for (int j = 0; j < MULTS; j++)
            bus.out_data[j] = valid ? mem[rd_buf][IW'(int'(rd_chunk) * MULTS + j)] : '0;
    end

endmodule

// File: doc/half_layer_collector.md
# half_layer_collector

Downstream stage of the half-precision vector-dot-vector block. Each scalar result of the dot-product unit arrives on `in_valid`/`in_data`. The block optionally applies ReLU to each result and gathers `NEURONS` of them into one layer-output vector. It then streams that vector out `MULTS` elements per beat under a valid/ready handshake, shaped as the `vector_b` input of the next layer's dot-product unit. Two vector buffers (ping-pong) let one layer collect while the previous one drains, because the upstream unit has no backpressure.

## Interface
Parameters:
- `BITS`, 16, element width (IEEE half)
- `NEURONS`, 10, results per layer vector; must be a multiple of `MULTS`
- `MULTS`, 2, elements per output beat

Ports (name, direction, width, meaning):
- `clk`  input  1  single clock, all logic on rising edge
- `rstn`  input  1  reset; asynchronous, active-low
- `in_valid`  input  1  `in_data` holds one dot-product result this cycle
- `in_data`  input  BITS  result scalar (upstream `c`)
- `out_valid`  output  1  `out_data` beat available
- `out_ready`  input  1  consumer accepts beat
- `out_data`  output  BITS x [MULTS]  unpacked array; element j = vector element `chunk*MULTS+j`
- `out_last`  output  1  high on the final beat of a vector (chunk `NEURONS/MULTS-1`)
- `overflow`  output  1  sticky; an input was dropped

## Operation
- Storage is two buffers, `buf[0..1][NEURONS]`, each with a `full` flag.
- Write side:
  - `wr_buf` and `wr_idx` (0..NEURONS-1) start at 0.
  - On `in_valid` with `full[wr_buf]==0`: write the activated value to `buf[wr_buf][wr_idx]` and increment `wr_idx`.
  - On the write at `wr_idx==NEURONS-1`: set `full[wr_buf]`, reset `wr_idx` to 0, and toggle `wr_buf`.
- Drop rule: on `in_valid` with `full[wr_buf]==1`, the input is dropped, `overflow` is set (cleared only by reset) and the pointers are unchanged.
- Read FSM has two states:
  - `IDLE`: moves to `SEND` when `full[rd_buf]==1`; `rd_chunk` is set to 0.
  - `SEND`: `out_valid=1`. On `out_valid&&out_ready`: if `rd_chunk==NEURONS/MULTS-1`, clear `full[rd_buf]`, toggle `rd_buf` and return to `IDLE`; otherwise increment `rd_chunk`.
- `out_data`, `out_last` and `out_valid` are driven from registers/buffer and stay stable while `out_valid && !out_ready`.
- Activation (when enabled):
  - If the sign bit is 1 and the value is not NaN (exponent all ones with nonzero mantissa), store 0x0000. This covers -0 and -inf.
  - Otherwise store the value unchanged.
  - NaN of either sign passes through.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=all 0, `overflow`=0. Internally: both `full` flags 0, FSM `IDLE`, all pointers 0. Buffer contents are not reset.
- Reset mid-operation: any partially collected or partially drained vector is discarded.
- Latency: the final element is written at edge N, `full` is visible after edge N, and `out_valid` rises after edge N+1 (IDLE→SEND). So the first beat is presented 2 cycles after the last input's `in_valid`.
- Throughput: one beat per cycle while `out_ready` is held high. A vector drains in `NEURONS/MULTS` cycles.
- Simultaneous events:
  - A `full` clear from a drain completing is not visible to the write side until the next cycle. An input arriving in that same cycle to that buffer is dropped and sets `overflow`.
  - Writing into one buffer while the other drains is always legal.
- `in_valid` is accepted every cycle without stall; there is no input ready.

## Configuration
- `HALF_RELU_EN` defined: ReLU is applied on write, as above.
- `HALF_RELU_EN` undefined: values are stored unmodified; timing is identical.

## Structure
- Shared package `half_nn_pkg`:
  - `half_t` typedef (16-bit), `HALF_SIGN_BIT`, `HALF_EXP_MASK`, `HALF_MANT_MASK`
  - function `half_is_nan`
  - FSM enum `collector_state_t {IDLE, SEND}`
- One combinational sub-module `half_relu` (in: `half_t`, out: `half_t`), instantiated only under `HALF_RELU_EN`.
- Elaboration assertion: `NEURONS % MULTS == 0`.

## Test plan
- Single vector with `HALF_RELU_EN`, NEURONS=4, MULTS=2, `out_ready`=1:
  - Inputs 0x3C00, 0xBC00, 0x8000, 0x7E00.
  - Beats {0x3C00,0x0000} then {0x0000,0x7E00}; `out_last` only on beat 2; first `out_valid` 2 cycles after the 4th input.
- Without `HALF_RELU_EN`, same inputs: beats {0x3C00,0xBC00} and {0x8000,0x7E00}.
- Backpressure: hold `out_ready`=0 for 5 cycles on beat 1. `out_data` and `out_valid` stay stable; beat 2 follows one cycle after `out_ready` rises.
- Ping-pong: feed 8 consecutive inputs 0x0001..0x0008 with `out_ready`=0. Both buffers fill and `overflow`=0. A 9th input sets `overflow`=1; then releasing `out_ready` yields 0x0001..0x0008 in order.
- Reset mid-drain: assert `rstn`=0 during beat 1. Outputs are 0 immediately; after release, no stale beat appears and a fresh vector drains correctly.
- Same-cycle free: with both buffers full, the final beat is accepted in the same cycle as `in_valid`. The input is dropped and `overflow`=1; the next input, one cycle later, is written to index 0 of the freed buffer.
